// File: rtl/bow_charge_ctrl.sv
// Bow draw/charge sequencer: steps the bow sprite through rest, half-drawn and fully-drawn
// poses on frame ticks and launches an arrow with the accumulated charge power on release.
module bow_charge_ctrl #(
    parameter int T1_FRAMES   = 8,
    parameter int T2_FRAMES   = 8,
    parameter int COOL_FRAMES = 6,
    parameter int PWR_MAX     = 15
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       vs,
    input  logic       fire_btn,
    input  logic       game_active,
    output logic [1:0] bow_sel,
    output logic [3:0] power,
    output logic       fire_pulse,
    output logic [3:0] arrow_power,
    output logic       busy
);

    localparam int MAX_FRAMES_A = (T1_FRAMES > T2_FRAMES) ? T1_FRAMES : T2_FRAMES;
    localparam int MAX_FRAMES   = (MAX_FRAMES_A > COOL_FRAMES) ? MAX_FRAMES_A : COOL_FRAMES;
    localparam int CNT_W        = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CNT_W-1:0] T1_LAST   = CNT_W'(T1_FRAMES - 1);
    localparam logic [CNT_W-1:0] T2_LAST   = CNT_W'(T2_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_FRAMES - 1);
    localparam logic [3:0]       PWR_SAT   = 4'(PWR_MAX);

    typedef enum logic [2:0] {
        IDLE,
        DRAW1,
        DRAW2,
        FULL,
        COOLDOWN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vs_q, vs_d;
    logic [1:0]       bow_sel_q, bow_sel_d;
    logic [3:0]       power_q, power_d;
    logic             fire_pulse_q, fire_pulse_d;
    logic [3:0]       arrow_power_q, arrow_power_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic [3:0]       power_inc;

    assign vs_d      = vs;
    assign tick      = vs_q & ~vs;
    assign power_inc = (power_q >= PWR_SAT) ? PWR_SAT : power_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        power_d       = power_q;
        fire_pulse_d  = 1'b0;
        arrow_power_d = arrow_power_q;

        if (!game_active) begin
            state_d = IDLE;
            cnt_d   = '0;
            power_d = 4'd0;
        end else if (tick) begin
            unique case (state_q)
                IDLE: begin
                    power_d = 4'd0;
                    if (fire_btn) begin
                        state_d = DRAW1;
                        cnt_d   = '0;
                        power_d = 4'd1;
                    end
                end
                DRAW1: begin
                    // A release here cancels, even on the tick that would advance to DRAW2
                    if (!fire_btn) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        power_d = 4'd0;
                    end else begin
                        power_d = power_inc;
                        if (cnt_q == T1_LAST) begin
                            state_d = DRAW2;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DRAW2, FULL: begin
                    if (!fire_btn) begin
                        fire_pulse_d  = 1'b1;
                        arrow_power_d = power_q;
                        power_d       = 4'd0;
                        state_d       = COOLDOWN;
                        cnt_d         = '0;
                    end else begin
                        power_d = power_inc;
                        if (state_q == DRAW2) begin
                            if (cnt_q == T2_LAST) begin
                                state_d = FULL;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                COOLDOWN: begin
                    power_d = 4'd0;
                    if (cnt_q == COOL_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    power_d = 4'd0;
                end
            endcase
        end

        // Sprite select and busy follow the next state so they change with it
        unique case (state_d)
            DRAW1:       bow_sel_d = 2'd1;
            DRAW2, FULL: bow_sel_d = 2'd2;
            default:     bow_sel_d = 2'd0;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            vs_q          <= 1'b0;
            bow_sel_q     <= 2'd0;
            power_q       <= 4'd0;
            fire_pulse_q  <= 1'b0;
            arrow_power_q <= 4'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            vs_q          <= vs_d;
            bow_sel_q     <= bow_sel_d;
            power_q       <= power_d;
            fire_pulse_q  <= fire_pulse_d;
            arrow_power_q <= arrow_power_d;
            busy_q        <= busy_d;
        end
    end

    assign bow_sel     = bow_sel_q;
    assign power       = power_q;
    assign fire_pulse  = fire_pulse_q;
    assign arrow_power = arrow_power_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bow_charge_ctrl.sv
// Directed testbench for bow_charge_ctrl: drives frame ticks and fire presses and compares
// outputs against hand-computed values.
module tb_bow_charge_ctrl;

    logic       vga_clk;
    logic       Reset;
    logic       vs;
    logic       fire_btn;
    logic       game_active;
    logic [1:0] bow_sel;
    logic [3:0] power;
    logic       fire_pulse;
    logic [3:0] arrow_power;
    logic       busy;

    int checks;
    int errors;
    int pulse_cnt;

    bow_charge_ctrl dut (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .vs          (vs),
        .fire_btn    (fire_btn),
        .game_active (game_active),
        .bow_sel     (bow_sel),
        .power       (power),
        .fire_pulse  (fire_pulse),
        .arrow_power (arrow_power),
        .busy        (busy)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Counts launch strobe cycles so "no pulse" and "exactly one pulse" can be checked
    always @(negedge vga_clk) begin
        if (fire_pulse === 1'b1) pulse_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One frame: fire_btn is inverted in the non-tick cycles and set to 'fire' on the tick cycle;
    // returns #1 after the edge that consumes the tick.
    task automatic applyStimulus(input logic fire);
        @(posedge vga_clk); #1;
        vs = 1'b1;
        fire_btn = ~fire;
        @(posedge vga_clk); #1;
        vs = 1'b0;
        fire_btn = fire;
        @(posedge vga_clk); #1;
    endtask

    task automatic checkAll(input string tag, input logic [1:0] e_sel, input logic [3:0] e_pwr,
                            input logic e_pulse, input logic [3:0] e_arrow, input logic e_busy);
        checkOutput({tag, ".bow_sel"}, 8'(bow_sel), 8'(e_sel));
        checkOutput({tag, ".power"}, 8'(power), 8'(e_pwr));
        checkOutput({tag, ".fire_pulse"}, 8'(fire_pulse), 8'(e_pulse));
        checkOutput({tag, ".arrow_power"}, 8'(arrow_power), 8'(e_arrow));
        checkOutput({tag, ".busy"}, 8'(busy), 8'(e_busy));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        pulse_cnt   = 0;
        Reset       = 1'b1;
        vs          = 1'b0;
        fire_btn    = 1'b1;
        game_active = 1'b1;

        // Reset with button held and vs low: no tick may ever appear
        repeat (3) @(posedge vga_clk);
        #1 Reset = 1'b0;
        checkAll("reset", 2'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        repeat (100) @(posedge vga_clk);
        #1;
        checkAll("vs_low_idle", 2'd0, 4'd0, 1'b0, 4'd0, 1'b0);

        // Short press cancelled in DRAW1
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1);
            checkOutput("cancel.bow_sel", 8'(bow_sel), 8'd1);
            checkOutput("cancel.power", 8'(power), 8'(i + 1));
            checkOutput("cancel.busy", 8'(busy), 8'd1);
        end
        applyStimulus(1'b0);
        checkAll("cancel_release", 2'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        checkOutput("cancel.pulse_cnt", 8'(pulse_cnt), 8'd0);

        // Long hold into FULL: power saturates at 15
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1);
            if (i == 8) checkOutput("hold.sel_t8", 8'(bow_sel), 8'd2);
            if (i == 14) checkOutput("hold.pwr_t14", 8'(power), 8'd15);
        end
        checkOutput("hold.sel_t29", 8'(bow_sel), 8'd2);
        checkOutput("hold.pwr_t29", 8'(power), 8'd15);
        pulse_cnt = 0;
        applyStimulus(1'b0);
        checkAll("hold_release", 2'd0, 4'd0, 1'b1, 4'd15, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0);
        checkOutput("hold.pulse_cnt", 8'(pulse_cnt), 8'd1);
        checkOutput("hold.cool_done", 8'(busy), 8'd0);

        // Release in DRAW2 at power 11, then cooldown ignores presses
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(1'b1);
            if (i == 8) begin
                checkOutput("shot.sel_t8", 8'(bow_sel), 8'd2);
                checkOutput("shot.pwr_t8", 8'(power), 8'd9);
            end
        end
        checkOutput("shot.pwr_t10", 8'(power), 8'd11);
        pulse_cnt = 0;
        applyStimulus(1'b0);
        checkAll("shot_release", 2'd0, 4'd0, 1'b1, 4'd11, 1'b1);
        @(posedge vga_clk); #1;
        checkOutput("shot.pulse_drop", 8'(fire_pulse), 8'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1);
            checkAll("cooldown", 2'd0, 4'd0, 1'b0, 4'd11, 1'b1);
        end
        applyStimulus(1'b1);
        checkAll("cool_exit", 2'd0, 4'd0, 1'b0, 4'd11, 1'b0);
        checkOutput("shot.pulse_cnt", 8'(pulse_cnt), 8'd1);

        // game_active dropped mid-frame in DRAW2 with power 10
        for (int i = 0; i <= 9; i++) applyStimulus(1'b1);
        checkOutput("abort.pre_pwr", 8'(power), 8'd10);
        checkOutput("abort.pre_sel", 8'(bow_sel), 8'd2);
        pulse_cnt = 0;
        game_active = 1'b0;
        @(posedge vga_clk); #1;
        checkAll("abort", 2'd0, 4'd0, 1'b0, 4'd11, 1'b0);
        fire_btn = 1'b0;
        repeat (2) @(posedge vga_clk);
        #1 game_active = 1'b1;
        checkOutput("abort.pulse_cnt", 8'(pulse_cnt), 8'd0);

        // Reset coincident with a tick during COOLDOWN
        for (int i = 0; i <= 8; i++) applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("rst_cool.arrow", 8'(arrow_power), 8'd9);
        applyStimulus(1'b0);
        checkOutput("rst_cool.busy", 8'(busy), 8'd1);
        @(posedge vga_clk); #1;
        vs = 1'b1;
        @(posedge vga_clk); #1;
        vs = 1'b0;
        Reset = 1'b1;
        @(posedge vga_clk); #1;
        Reset = 1'b0;
        checkAll("rst_cool", 2'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1);
        checkAll("rst_restart", 2'd1, 4'd1, 1'b0, 4'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
